ps2_scancode_decoder: RTL and testbench
=======================================

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 Parameter DEPTH, default 4: number of key-event FIFO entries; SHALL be a power of 2 and at least 2.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-low: low clears all state immediately.
REQ-004 code_valid  input  1  level-high flag from the PS/2 receiver; a scan byte is available when it rises.
REQ-005 code_in  input  8  scan byte from the PS/2 receiver; stable while code_valid is high.
REQ-006 evt_ack  input  1  consumer pop strobe; ignored when evt_valid=0.
REQ-007 evt_valid  output  1  FIFO non-empty; the head event is presented on evt_code, evt_ext and evt_release.
REQ-008 evt_code  output  8  head event base scan code, with E0 and F0 prefixes stripped.
REQ-009 evt_ext  output  1  head event carried an E0 (extended) prefix.
REQ-010 evt_release  output  1  head event is a break code (F0 prefix).
REQ-011 evt_count  output  clog2(DEPTH)+1  number of FIFO entries currently held.
REQ-012 overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
REQ-013 proto_err  output  1  one-cycle pulse when an illegal byte sequence is discarded.

Function
REQ-014 Byte accept SHALL occur on any clk edge where code_valid=1 and its registered previous value=0, capturing code_in on that same edge; a code_valid level held high SHALL yield exactly one accept.
REQ-015 The prefix FSM SHALL have four states: IDLE, GOT_E0, GOT_F0 and GOT_E0F0; state changes occur only on an accept.
REQ-016 In IDLE: byte E0 -> GOT_E0; byte F0 -> GOT_F0; any other byte -> emit {ext=0, rel=0, code}, stay in IDLE.
REQ-017 In GOT_E0: byte F0 -> GOT_E0F0; byte E0 -> stay in GOT_E0; any other byte -> emit {ext=1, rel=0}, go to IDLE.
REQ-018 In GOT_F0: byte F0 -> stay in GOT_F0; byte E0 -> pulse proto_err, go to GOT_E0; any other byte -> emit {ext=0, rel=1}, go to IDLE.
REQ-019 In GOT_E0F0: byte E0 or F0 -> pulse proto_err, go to IDLE with no emit; any other byte -> emit {ext=1, rel=1}, go to IDLE.
REQ-020 Bytes 00 and FF (keyboard overrun/error) in any state SHALL pulse proto_err, force IDLE and emit nothing.
REQ-021 An emit SHALL write the FIFO on the accept edge, so evt_valid/evt_count reflect the new event in the cycle immediately after the accept (1-cycle latency).
REQ-022 FIFO SHALL be first-word-fall-through: the head is valid on the outputs whenever evt_valid=1; a pop occurs on an edge with evt_ack=1 and evt_valid=1.
REQ-023 Emit while full with no pop: the event is dropped, contents are unchanged and overflow is set; overflow SHALL stay set until reset.
REQ-024 Emit and pop on the same edge while full: both SHALL occur, with no drop and no change to evt_count.
REQ-025 Emit and pop on the same edge while non-empty and not full: evt_count SHALL be unchanged and order SHALL be preserved.
REQ-026 Emit while empty: evt_valid=1 on the next cycle; evt_ack with evt_valid=0 has no effect.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; evt_count SHALL never exceed DEPTH or go below 0.

Reset
REQ-028 While reset=0: FSM=IDLE, FIFO empty, evt_count=0, evt_valid=0, evt_code=00, evt_ext=0, evt_release=0, overflow=0, proto_err=0.
REQ-029 While reset=0, the previous-code_valid register SHALL be set to 1, so a code_valid held high across reset release is not accepted.
REQ-030 Reset asserted mid-sequence (e.g. after E0) SHALL discard the partial prefix; the next byte is decoded from IDLE.

Verification
REQ-031 Bytes 1C, then F0 1C -> two events: {1C, ext=0, rel=0} then {1C, ext=0, rel=1}; evt_count goes 1, then 2.
REQ-032 Bytes E0 75, then E0 F0 75 -> events {75, 1, 0} then {75, 1, 1}; proto_err never pulses.
REQ-033 With DEPTH=4, six make codes 15 16 1E 26 25 2E and no evt_ack -> evt_count=4, overflow=1, FIFO holds 15 16 1E 26 in that order.
REQ-034 FIFO full, with evt_ack held on the same edge as a 5th accept -> no drop, overflow stays 0, and the 5th code is popped last.
REQ-035 Byte sequences E0 F0 F0, then FF, then F0 E0 74 -> proto_err pulses three times; the only event emitted is {74, 1, 0}.
REQ-036 code_valid held high for 10 cycles with code_in=1C -> exactly one event; code_valid high through a reset pulse -> no event after release.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_decoder
// Description : Turns a stream of PS/2 set-2 scan bytes into key events.
//               E0 (extended) and F0 (break) prefixes are folded into flags
//               on each event. Events are queued in a first-word-fall-through
//               FIFO. A sticky overflow flag reports dropped events, and a
//               one-cycle proto_err pulse reports discarded byte sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_decoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     code_valid,
  input  logic [7:0]               code_in,
  input  logic                     evt_ack,
  output logic                     evt_valid,
  output logic [7:0]               evt_code,
  output logic                     evt_ext,
  output logic                     evt_release,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        code_valid_q;
  logic        accept;
  logic        emit;
  logic        emit_ext;
  logic        emit_rel;
  logic        seq_err;

  logic [9:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] count;
  logic        full;
  logic        push;
  logic        pop;
  logic [9:0]  head;

  // A byte is taken only on the rising edge of code_valid.
  assign accept = code_valid & ~code_valid_q;

  // Edge-detect history. It resets high so that a level held across reset
  // release does not look like a new byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) code_valid_q <= 1'b1;
    else        code_valid_q <= code_valid;
  end

  // Prefix FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Prefix FSM next-state and emit decode. It only moves on an accepted byte.
  always_comb begin
    next_state = state;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_rel   = 1'b0;
    seq_err    = 1'b0;
    if (accept) begin
      if (code_in == 8'h00 || code_in == 8'hFF) begin
        // Keyboard overrun/error bytes abandon any partial sequence.
        seq_err    = 1'b1;
        next_state = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (code_in == 8'hE0)      next_state = GOT_E0;
            else if (code_in == 8'hF0) next_state = GOT_F0;
            else                       emit = 1'b1;
          end
          GOT_E0: begin
            if (code_in == 8'hF0)      next_state = GOT_E0F0;
            else if (code_in == 8'hE0) next_state = GOT_E0;
            else begin
              emit       = 1'b1;
              emit_ext   = 1'b1;
              next_state = IDLE;
            end
          end
          GOT_F0: begin
            if (code_in == 8'hF0) next_state = GOT_F0;
            else if (code_in == 8'hE0) begin
              // A break prefix followed by an extended prefix: drop the
              // break and continue with the extended sequence.
              seq_err    = 1'b1;
              next_state = GOT_E0;
            end else begin
              emit       = 1'b1;
              emit_rel   = 1'b1;
              next_state = IDLE;
            end
          end
          GOT_E0F0: begin
            if (code_in == 8'hE0 || code_in == 8'hF0) begin
              seq_err    = 1'b1;
              next_state = IDLE;
            end else begin
              emit       = 1'b1;
              emit_ext   = 1'b1;
              emit_rel   = 1'b1;
              next_state = IDLE;
            end
          end
          default: next_state = IDLE;
        endcase
      end
    end
  end

  // A write goes through when full only if the head leaves on the same edge.
  assign full = (count == FULL_COUNT);
  assign pop  = evt_ack & (count != '0);
  assign push = emit & (~full | pop);

  // FIFO storage. The entries need no reset because the outputs are gated
  // by evt_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {emit_ext, emit_rel, code_in};
  end

  // FIFO pointers, occupancy, sticky overflow and the error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= seq_err;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (emit && full && !pop) overflow <= 1'b1;
    end
  end

  assign head        = mem[rd_ptr];
  assign evt_valid   = (count != '0);
  assign evt_count   = count;
  assign evt_code    = evt_valid ? head[7:0] : 8'h00;
  assign evt_release = evt_valid & head[8];
  assign evt_ext     = evt_valid & head[9];

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scancode_decoder
// Description : Directed self-checking bench for ps2_scancode_decoder. The
//               expected events are queued as bytes are driven and compared
//               as the FIFO is drained.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] code_in;
  logic       evt_ack;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_release;
  logic [2:0] evt_count;
  logic       overflow;
  logic       proto_err;

  int checks   = 0;
  int failures = 0;
  int err_pulses = 0;
  logic [9:0] sb [$];

  ps2_scancode_decoder #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .code_valid  (code_valid),
    .code_in     (code_in),
    .evt_ack     (evt_ack),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .evt_ext     (evt_ext),
    .evt_release (evt_release),
    .evt_count   (evt_count),
    .overflow    (overflow),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  // Count proto_err pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (proto_err === 1'b1) err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for a single cycle, then hold code_valid low a cycle.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    code_in    = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  // Byte that produces an event: queue the expected {ext, rel, code}.
  task automatic send_expect(input logic [7:0] b, input logic ext, input logic rel);
    sb.push_back({ext, rel, b});
    send_byte(b);
  endtask

  // Pop every DUT event and compare each one with the scoreboard head.
  task automatic drain(input string tag);
    int guard = 0;
    logic [9:0] exp;
    while (sb.size() > 0) begin
      @(negedge clk);
      evt_ack = 1'b0;
      if (evt_valid === 1'b1) begin
        exp = sb.pop_front();
        check(tag, {22'd0, evt_ext, evt_release, evt_code}, {22'd0, exp});
        evt_ack = 1'b1;
      end else begin
        guard++;
        if (guard > 20) begin
          check({tag, "_timeout"}, 32'd0, 32'd1);
          sb.delete();
        end
      end
    end
    @(negedge clk);
    evt_ack = 1'b0;
    check({tag, "_empty"}, {31'd0, evt_valid}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int base;
    reset      = 1'b0;
    code_valid = 1'b0;
    code_in    = 8'h00;
    evt_ack    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_valid",    {31'd0, evt_valid},   32'd0);
    check("rst_count",    {29'd0, evt_count},   32'd0);
    check("rst_code",     {24'd0, evt_code},    32'd0);
    check("rst_ext_rel",  {30'd0, evt_ext, evt_release}, 32'd0);
    check("rst_overflow", {31'd0, overflow},    32'd0);
    check("rst_proto",    {31'd0, proto_err},   32'd0);
    reset = 1'b1;

    // Ack while empty does nothing.
    @(negedge clk); evt_ack = 1'b1;
    @(negedge clk); evt_ack = 1'b0;
    check("ack_empty_count", {29'd0, evt_count}, 32'd0);

    // Make then break of 1C.
    send_expect(8'h1C, 1'b0, 1'b0);
    check("make_count", {29'd0, evt_count}, 32'd1);
    check("make_valid", {31'd0, evt_valid}, 32'd1);
    send_byte(8'hF0);
    send_expect(8'h1C, 1'b0, 1'b1);
    check("break_count", {29'd0, evt_count}, 32'd2);
    drain("make_break");

    // Extended make and break; no protocol errors expected.
    base = err_pulses;
    send_byte(8'hE0);
    send_expect(8'h75, 1'b1, 1'b0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_expect(8'h75, 1'b1, 1'b1);
    check("ext_proto", err_pulses - base, 32'd0);
    drain("ext");

    // Overflow: six makes into a four-entry FIFO, no acks.
    send_expect(8'h15, 1'b0, 1'b0);
    send_expect(8'h16, 1'b0, 1'b0);
    send_expect(8'h1E, 1'b0, 1'b0);
    send_expect(8'h26, 1'b0, 1'b0);
    check("full_overflow0", {31'd0, overflow}, 32'd0);
    send_byte(8'h25);
    send_byte(8'h2E);
    check("ovf_count", {29'd0, evt_count}, 32'd4);
    check("ovf_flag",  {31'd0, overflow},  32'd1);
    drain("ovf_order");
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    pulse_reset();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO: 5th accept with ack on the same edge.
    send_expect(8'h15, 1'b0, 1'b0);
    send_expect(8'h16, 1'b0, 1'b0);
    send_expect(8'h1E, 1'b0, 1'b0);
    send_expect(8'h26, 1'b0, 1'b0);
    @(negedge clk);
    begin
      logic [9:0] exp;
      exp = sb.pop_front();
      check("simul_head", {22'd0, evt_ext, evt_release, evt_code}, {22'd0, exp});
    end
    sb.push_back({2'b00, 8'h25});
    code_in    = 8'h25;
    code_valid = 1'b1;
    evt_ack    = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    evt_ack    = 1'b0;
    check("simul_count",    {29'd0, evt_count}, 32'd4);
    check("simul_overflow", {31'd0, overflow},  32'd0);
    drain("simul_order");

    // Illegal sequences: three error pulses, one event {74, ext}.
    base = err_pulses;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'hF0);
    send_byte(8'hFF);
    send_byte(8'hF0);
    send_byte(8'hE0);
    send_expect(8'h74, 1'b1, 1'b0);
    @(negedge clk);
    check("err_pulses", err_pulses - base, 32'd3);
    check("err_count",  {29'd0, evt_count}, 32'd1);
    drain("err_evt");

    // Reset mid-sequence drops the pending E0.
    send_byte(8'hE0);
    pulse_reset();
    send_expect(8'h1C, 1'b0, 1'b0);
    drain("mid_reset");

    // Level held high: one event only.
    sb.push_back({2'b00, 8'h1C});
    @(negedge clk);
    code_in    = 8'h1C;
    code_valid = 1'b1;
    repeat (10) @(negedge clk);
    code_valid = 1'b0;
    check("hold_count", {29'd0, evt_count}, 32'd1);
    drain("hold");

    // code_valid high through a reset pulse: nothing accepted after release.
    @(negedge clk);
    code_valid = 1'b1;
    @(negedge clk);
    check("hold_pre_reset", {29'd0, evt_count}, 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    code_valid = 1'b0;
    check("hold_reset_count", {29'd0, evt_count}, 32'd0);
    check("hold_reset_valid", {31'd0, evt_valid}, 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
